// File: rtl/msg_serializer_pkg.sv
// Shared definitions for the message serializer: state encoding, beat tags,
// packet lengths and the beat-to-tag mapping used by the output mux.
package msg_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [1:0] TAG_RS_MSG  = 2'd0;
  localparam logic [1:0] TAG_RT_MSG  = 2'd1;
  localparam logic [1:0] TAG_RT_DATA = 2'd2;
  localparam logic [1:0] TAG_RD_DATA = 2'd3;

  localparam int MSG_BEATS  = 4;
  localparam int DATA_BEATS = 2;

  // A message packet walks the tags 0..3 in order, while a data packet only
  // carries the last two fields, so its tag is the beat index shifted by two.
  function automatic logic [1:0] beatTag(input logic fp, input logic [1:0] beat);
    return fp ? beat : (beat + TAG_RT_DATA);
  endfunction

endpackage

// File: rtl/msg_serializer.sv
// Serializes one captured operand/message bundle into a stream of 32-bit
// beats. FP bundles go out as four beats (Rs_MSG, Rt_MSG, Rt_data, Rd_data),
// plain data bundles as two beats (Rt_data, Rd_data). A new bundle can be
// taken on the last beat so back-to-back packets leave with no idle cycle.
module msg_serializer
  import msg_serializer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              FP,
  input  logic [DATA_W-1:0] Rs_MSG,
  input  logic [DATA_W-1:0] Rt_data_ID,
  input  logic [DATA_W-1:0] Rt_MSG,
  input  logic [DATA_W-1:0] Rd_data_ID,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_word,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_last,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        beat_q;
  logic [1:0]        beat_d;
  logic              fp_q;
  logic [DATA_W-1:0] rsMsg_q;
  logic [DATA_W-1:0] rtMsg_q;
  logic [DATA_W-1:0] rtData_q;
  logic [DATA_W-1:0] rdData_q;

  logic              sending;
  logic              lastBeat;
  logic              accept;
  logic              beatDone;
  logic [1:0]        curTag;
  logic [DATA_W-1:0] curWord;

  // Select the field for the current beat and decide whether it closes the packet.
  always_comb begin
    sending  = (state_q == SEND);
    curTag   = beatTag(fp_q, beat_q);
    lastBeat = fp_q ? (beat_q == 2'(MSG_BEATS - 1)) : (beat_q == 2'(DATA_BEATS - 1));
    beat_d   = beat_q + 2'd1;
    curWord  = '0;
    case (curTag)
      TAG_RS_MSG:  curWord = rsMsg_q;
      TAG_RT_MSG:  curWord = rtMsg_q;
      TAG_RT_DATA: curWord = rtData_q;
      TAG_RD_DATA: curWord = rdData_q;
      default:     curWord = '0;
    endcase
  end

  // Outputs are gated by the state so nothing stale shows on the bus while idle.
  assign out_valid = sending;
  assign busy      = sending;
  assign out_word  = sending ? curWord : '0;
  assign out_tag   = sending ? TAG_W'(curTag) : '0;
  assign out_last  = sending & lastBeat;
  assign in_ready  = (state_q == IDLE) | (sending & lastBeat & out_ready);
  assign accept    = in_valid & in_ready;
  assign beatDone  = sending & out_ready;

  // Packet FSM: capture on accept, advance one beat per transfer, and either
  // chain straight into the next bundle or drop back to idle after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      fp_q     <= 1'b0;
      rsMsg_q  <= '0;
      rtMsg_q  <= '0;
      rtData_q <= '0;
      rdData_q <= '0;
    end else begin
      if (accept) begin
        fp_q     <= FP;
        rsMsg_q  <= Rs_MSG;
        rtMsg_q  <= Rt_MSG;
        rtData_q <= Rt_data_ID;
        rdData_q <= Rd_data_ID;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SEND;
            beat_q  <= '0;
          end
        end
        SEND: begin
          if (beatDone) begin
            if (lastBeat) begin
              beat_q  <= '0;
              state_q <= accept ? SEND : IDLE;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serializer.sv
// Directed bench for the message serializer. A queue of expected beats is
// filled from every accepted bundle and drained on every transfer; a compare
// process checks the DUT against it each cycle, and the directed sequence
// adds literal expectations for the key beats.
module tb_msg_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        FP;
  logic [31:0] Rs_MSG;
  logic [31:0] Rt_data_ID;
  logic [31:0] Rt_MSG;
  logic [31:0] Rd_data_ID;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [1:0]  out_tag;
  logic        out_last;
  logic        busy;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  tag;
    logic        last;
  } beat_t;

  beat_t expQ[$];
  int    vectors    = 0;
  int    miscompares = 0;
  logic  checkEn    = 1'b0;

  msg_serializer #(.DATA_W(32), .TAG_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .FP         (FP),
    .Rs_MSG     (Rs_MSG),
    .Rt_data_ID (Rt_data_ID),
    .Rt_MSG     (Rt_MSG),
    .Rd_data_ID (Rd_data_ID),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_tag    (out_tag),
    .out_last   (out_last),
    .busy       (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by the model checker and the literal checks.
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a bundle turns into its list of beats; the list drains one per transfer.
  always @(posedge clk) begin
    logic mdlReady;
    if (rst) begin
      expQ.delete();
    end else begin
      mdlReady = (expQ.size() == 0) || (expQ.size() == 1 && out_ready);
      if (expQ.size() > 0 && out_ready) void'(expQ.pop_front());
      if (in_valid && mdlReady) begin
        if (FP) begin
          expQ.push_back('{Rs_MSG,     2'd0, 1'b0});
          expQ.push_back('{Rt_MSG,     2'd1, 1'b0});
          expQ.push_back('{Rt_data_ID, 2'd2, 1'b0});
          expQ.push_back('{Rd_data_ID, 2'd3, 1'b1});
        end else begin
          expQ.push_back('{Rt_data_ID, 2'd2, 1'b0});
          expQ.push_back('{Rd_data_ID, 2'd3, 1'b1});
        end
      end
    end
  end

  // Every-cycle compare of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      cmp("mdl_valid", 32'(out_valid), 32'(expQ.size() > 0));
      cmp("mdl_busy", 32'(busy), 32'(expQ.size() > 0));
      cmp("mdl_in_ready", 32'(in_ready),
          32'((expQ.size() == 0) || (expQ.size() == 1 && out_ready)));
      if (expQ.size() > 0) begin
        cmp("mdl_word", out_word, expQ[0].word);
        cmp("mdl_tag", 32'(out_tag), 32'(expQ[0].tag));
        cmp("mdl_last", 32'(out_last), 32'(expQ[0].last));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic fp, input logic [31:0] rs,
                               input logic [31:0] rtm, input logic [31:0] rtd,
                               input logic [31:0] rd, input logic ordy);
    in_valid   = v;
    FP         = fp;
    Rs_MSG     = rs;
    Rt_MSG     = rtm;
    Rt_data_ID = rtd;
    Rd_data_ID = rd;
    out_ready  = ordy;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expWord,
                             input logic [1:0] expTag, input logic expLast);
    cmp({name, "_valid"}, 32'(out_valid), 32'(expValid));
    if (expValid) begin
      cmp({name, "_word"}, out_word, expWord);
      cmp({name, "_tag"}, 32'(out_tag), 32'(expTag));
      cmp({name, "_last"}, 32'(out_last), 32'(expLast));
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
    checkEn = 1'b1;

    // Reset state
    checkOutput("rst", 1'b0, '0, '0, 1'b0);
    cmp("rst_word", out_word, 32'h0);
    cmp("rst_tag", 32'(out_tag), 32'h0);
    cmp("rst_busy", 32'(busy), 32'h0);
    cmp("rst_in_ready", 32'(in_ready), 32'h1);

    // Message packet, no backpressure
    applyStimulus(1'b1, 1'b1, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("msg_b0", 1'b1, 32'hA1, 2'd0, 1'b0);
    cycle();
    checkOutput("msg_b1", 1'b1, 32'hB2, 2'd1, 1'b0);
    cycle();
    checkOutput("msg_b2", 1'b1, 32'hC3, 2'd2, 1'b0);
    cycle();
    checkOutput("msg_b3", 1'b1, 32'hD4, 2'd3, 1'b1);
    cycle();
    checkOutput("msg_idle", 1'b0, '0, '0, 1'b0);

    // Data packet
    applyStimulus(1'b1, 1'b0, 32'hEE, 32'hEE, 32'h11, 32'h22, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("dat_b0", 1'b1, 32'h11, 2'd2, 1'b0);
    cycle();
    checkOutput("dat_b1", 1'b1, 32'h22, 2'd3, 1'b1);
    cmp("dat_last_in_ready", 32'(in_ready), 32'h1);
    cycle();
    checkOutput("dat_idle", 1'b0, '0, '0, 1'b0);
    cmp("dat_idle_in_ready", 32'(in_ready), 32'h1);

    // Backpressure at beat 1 with changing inputs
    applyStimulus(1'b1, 1'b1, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("bp_b0", 1'b1, 32'hA1, 2'd0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'hDEAD0000 + 32'(i), 32'hBAD, 32'hBEEF, 32'hCAFE, 1'b0);
      checkOutput("bp_hold", 1'b1, 32'hB2, 2'd1, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8, 1'b1);
    checkOutput("bp_b1", 1'b1, 32'hB2, 2'd1, 1'b0);
    cycle();
    checkOutput("bp_b2", 1'b1, 32'hC3, 2'd2, 1'b0);
    cycle();
    checkOutput("bp_b3", 1'b1, 32'hD4, 2'd3, 1'b1);
    cycle();
    checkOutput("bp_idle", 1'b0, '0, '0, 1'b0);

    // Back-to-back data packets
    applyStimulus(1'b1, 1'b0, '0, '0, 32'h11, 32'h22, 1'b1);
    cycle();
    applyStimulus(1'b1, 1'b0, '0, '0, 32'h33, 32'h44, 1'b1);
    checkOutput("b2b_b0", 1'b1, 32'h11, 2'd2, 1'b0);
    cmp("b2b_b0_in_ready", 32'(in_ready), 32'h0);
    cycle();
    checkOutput("b2b_b1", 1'b1, 32'h22, 2'd3, 1'b1);
    cmp("b2b_b1_in_ready", 32'(in_ready), 32'h1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("b2b_b2", 1'b1, 32'h33, 2'd2, 1'b0);
    cycle();
    checkOutput("b2b_b3", 1'b1, 32'h44, 2'd3, 1'b1);
    cycle();
    checkOutput("b2b_idle", 1'b0, '0, '0, 1'b0);

    // Reset in the middle of a message packet
    applyStimulus(1'b1, 1'b1, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    cycle();
    cycle();
    checkOutput("mid_b2", 1'b1, 32'hC3, 2'd2, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("mid_rst", 1'b0, '0, '0, 1'b0);
    cmp("mid_rst_busy", 32'(busy), 32'h0);
    cmp("mid_rst_in_ready", 32'(in_ready), 32'h1);
    cmp("mid_rst_word", out_word, 32'h0);
    applyStimulus(1'b1, 1'b0, '0, '0, 32'h55, 32'h66, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("post_b0", 1'b1, 32'h55, 2'd2, 1'b0);
    cycle();
    checkOutput("post_b1", 1'b1, 32'h66, 2'd3, 1'b1);
    cycle();
    checkOutput("post_idle", 1'b0, '0, '0, 1'b0);

    // Reset wins over a simultaneous accept
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, '0, 32'h77, 32'h88, 1'b1);
    cycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checkOutput("rst_acc0", 1'b0, '0, '0, 1'b0);
    cycle();
    checkOutput("rst_acc1", 1'b0, '0, '0, 1'b0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
